// File: rtl/res_word_streamer_pkg.sv
// Shared widths and state encoding for the residual word streamer.
// The optional skip-zero mode is selected with the RES_STREAM_SKIP_ZERO_EN macro.
package res_word_streamer_pkg;

  localparam int ROM_DATA_WIDTH     = 16;
  localparam int REG_RES_SIZE       = 8;
  localparam int REG_RES_ADDR_WIDTH = 3;

  typedef enum logic {
    RES_STREAM_IDLE = 1'b0,
    RES_STREAM_BUSY = 1'b1
  } res_stream_state_e;

endpackage : res_word_streamer_pkg

// File: rtl/res_next_nz.sv
// Combinational priority finder over a nonzero-word mask: next set bit above cur_i,
// the lowest set bit overall, and the matching "nothing found" flags.
module res_next_nz #(
  parameter int NUM_WORDS  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic [NUM_WORDS-1:0]  mask_i,
  input  logic [ADDR_WIDTH-1:0] cur_i,
  output logic [ADDR_WIDTH-1:0] next_idx_o,
  output logic                  none_left_o,
  output logic [ADDR_WIDTH-1:0] first_idx_o,
  output logic                  all_zero_o
);

  // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    next_idx_o  = '0;
    none_left_o = 1'b1;
    first_idx_o = '0;
    all_zero_o  = 1'b1;
    // Scan downwards so the lowest qualifying index is the last one written.
    for (int i = NUM_WORDS - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        first_idx_o = ADDR_WIDTH'(i);
        all_zero_o  = 1'b0;
        if (i > int'(cur_i)) begin
          next_idx_o  = ADDR_WIDTH'(i);
          none_left_o = 1'b0;
        end
      end
    end
  end

endmodule : res_next_nz

// File: rtl/res_word_streamer.sv
// Captures a flat residual vector on load and streams it out one word per beat.
// Define RES_STREAM_SKIP_ZERO_EN to emit only the nonzero words.
module res_word_streamer
  import res_word_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int NUM_WORDS  = REG_RES_SIZE,
  parameter int ADDR_WIDTH = REG_RES_ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] D,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [ADDR_WIDTH-1:0]           out_addr,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);

  localparam int VEC_W = DATA_WIDTH * NUM_WORDS;

  res_stream_state_e       state_q, state_d;
  logic [VEC_W-1:0]        snap_q, snap_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;

  logic [NUM_WORDS-1:0]    nz_mask;
  logic [ADDR_WIDTH-1:0]   next_idx, first_idx;
  logic                    none_left, all_zero;

  function automatic logic [DATA_WIDTH-1:0] word_at(input logic [VEC_W-1:0] v,
                                                     input logic [ADDR_WIDTH-1:0] idx);
    return v[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic any_above(input logic [NUM_WORDS-1:0] m,
                                     input logic [ADDR_WIDTH-1:0] pos);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (i > int'(pos) && m[i]) hit = 1'b1;
    end
    return hit;
  endfunction

`ifdef RES_STREAM_SKIP_ZERO_EN
  // In IDLE the incoming vector decides the first beat; afterwards only the snapshot matters.
  logic [VEC_W-1:0] mask_src;
  assign mask_src = (state_q == RES_STREAM_IDLE) ? D : snap_q;

  always_comb begin
    nz_mask = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      nz_mask[i] = |mask_src[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end
`else
  // Every word counts as present, so the finder degenerates to a plain 0..N-1 walk.
  assign nz_mask = '1;
`endif

  res_next_nz #(
    .NUM_WORDS  (NUM_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_nz (
    .mask_i      (nz_mask),
    .cur_i       (addr_q),
    .next_idx_o  (next_idx),
    .none_left_o (none_left),
    .first_idx_o (first_idx),
    .all_zero_o  (all_zero)
  );

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    done_d  = 1'b0;

    unique case (state_q)
      RES_STREAM_IDLE: begin
        if (load) begin
          snap_d = D;
          if (all_zero) begin
            done_d = 1'b1;
          end else begin
            state_d = RES_STREAM_BUSY;
            valid_d = 1'b1;
            addr_d  = first_idx;
            data_d  = word_at(D, first_idx);
            last_d  = !any_above(nz_mask, first_idx);
          end
        end
      end
      RES_STREAM_BUSY: begin
        if (valid_q && out_ready) begin
          if (none_left) begin
            state_d = RES_STREAM_IDLE;
            valid_d = 1'b0;
            data_d  = '0;
            addr_d  = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = next_idx;
            data_d = word_at(snap_q, next_idx);
            last_d = !any_above(nz_mask, next_idx);
          end
        end
      end
      default: state_d = RES_STREAM_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RES_STREAM_IDLE;
      // NOTE: the snapshot is reset too, so a stale vector can never leak after reset.
      snap_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign busy      = (state_q == RES_STREAM_BUSY);
  assign done      = done_q;

endmodule : res_word_streamer

// File: tb/tb_res_word_streamer.sv
// Scoreboard bench for res_word_streamer: a reference model queues expected beats on
// every accepted load, a monitor pops and compares each transferred beat.
module tb_res_word_streamer;

  localparam int DW = 16;
  localparam int NW = 8;
  localparam int AW = 3;
`ifdef RES_STREAM_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic             clk, rst, load, out_ready;
  logic [DW*NW-1:0] D;
  logic             out_valid, out_last, busy, done;
  logic [DW-1:0]    out_data;
  logic [AW-1:0]    out_addr;

  int checks = 0;
  int errors = 0;

  beat_t exp_q[$];
  bit    model_busy = 1'b0;
  bit    exp_done   = 1'b0;
  bit    prev_hold  = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;
  logic          prev_last;

  res_word_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .D         (D),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the words a vector should produce, in emission order.
  function automatic void expect_vector(input logic [DW*NW-1:0] v);
    beat_t b;
    for (int i = 0; i < NW; i++) begin
      b.addr = AW'(i);
      b.data = v[i*DW +: DW];
      b.last = 1'b0;
      if (!SKIP || b.data != '0) exp_q.push_back(b);
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endfunction

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    beat_t e;
    bit    was_busy;
    if (rst) begin
      exp_q.delete();
      model_busy = 1'b0;
      exp_done   = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      check("done", done, exp_done);
      check("busy", busy, model_busy);
      check("out_valid", out_valid, model_busy);
      if (prev_hold) begin
        check("hold_data", out_data, prev_data);
        check("hold_addr", out_addr, prev_addr);
        check("hold_last", out_last, prev_last);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_addr = out_addr;
      prev_last = out_last;
      exp_done  = 1'b0;
      was_busy  = model_busy;
      if (was_busy) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("beat_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat_addr", out_addr, e.addr);
            check("beat_data", out_data, e.data);
            check("beat_last", out_last, e.last);
            if (e.last) begin
              model_busy = 1'b0;
              exp_done   = 1'b1;
            end
          end
        end
      end else if (load) begin
        expect_vector(D);
        if (exp_q.size() == 0) exp_done = 1'b1;
        else model_busy = 1'b1;
      end
    end
  end

  function automatic logic [DW*NW-1:0] seq_vec(input int base);
    logic [DW*NW-1:0] v;
    for (int i = 0; i < NW; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  function automatic logic [DW*NW-1:0] rand_vec();
    logic [DW*NW-1:0] v;
    for (int i = 0; i < NW; i++) begin
      if (SKIP && ($urandom % 2) == 0) v[i*DW +: DW] = '0;
      else v[i*DW +: DW] = DW'($urandom);
    end
    return v;
  endfunction

  task automatic do_load(input logic [DW*NW-1:0] v);
    @(posedge clk); #1;
    D    = v;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit got = 1'b0;
    for (int c = 0; c < bound && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("wait_done_timeout", got, 1);
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, input int bound);
    bit got = 1'b0;
    for (int c = 0; c < bound && !got; c++) begin
      @(negedge clk);
      if (out_valid && out_addr == a) got = 1'b1;
    end
    check("wait_addr_timeout", got, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_addr"},  out_addr,  0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
  endtask

  initial begin
    logic [DW*NW-1:0] v1, v2, vs;
    rst = 1'b1; load = 1'b0; D = '0; out_ready = 1'b1;
    v1 = seq_vec(1);
    v2 = seq_vec(16'h0100);

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Basic stream with the consumer always ready.
    do_load(v1);
    wait_done(20);

    // Back-pressure while the word at index 2 is presented.
    do_load(v1);
    wait_addr(1, 20);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(20);

    // A load during a stream must be ignored; the new vector streams only afterwards.
    do_load(v1);
    wait_addr(3, 20);
    @(posedge clk); #1;
    D = v2; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    wait_done(20);
    do_load(v2);
    wait_done(20);

    // Asynchronous reset in the middle of a stream.
    do_load(v1);
    wait_addr(3, 20);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_load(v1);
    wait_done(20);

`ifdef RES_STREAM_SKIP_ZERO_EN
    vs = '0;
    vs[1*DW +: DW] = 16'h00A0;
    vs[4*DW +: DW] = 16'h0BEE;
    do_load(vs);
    wait_done(20);
    do_load('0);
    wait_done(3);
`endif

    // Randomized traffic: random vectors, back-pressure, stray loads and D changes.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom % 4) != 0;
      load      = ($urandom % 6) == 0;
      if (($urandom % 3) == 0) D = rand_vec();
    end
    @(posedge clk); #1;
    load      = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_res_word_streamer

// File: doc/res_word_streamer.md
# res_word_streamer

Unpacks a full residual vector, presented as one flat bus, into a stream of single words with a valid/ready handshake and a word index. It is the read-out counterpart of the residual register file, which accepts one addressed word per write and presents all words in parallel. The streamer sits between that flat residual snapshot and downstream word-serial consumers (correlator, norm unit, host readback). It captures the vector on a load pulse and then emits the words in index order.

## Interface
Parameters:
- DATA_WIDTH, default `ROM_DATA_WIDTH (16): width of one residual word.
- NUM_WORDS, default `REG_RES_SIZE (8): number of words in the vector.
- ADDR_WIDTH, default `REG_RES_ADDR_WIDTH (3): index width; must satisfy 2^ADDR_WIDTH >= NUM_WORDS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- load  in  1  start request; sampled only in IDLE.
- D  in  DATA_WIDTH*NUM_WORDS  flat vector; word i = D[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
- out_ready  in  1  consumer accepts the current beat.
- out_valid  out  1  beat available.
- out_data  out  DATA_WIDTH  current word.
- out_addr  out  ADDR_WIDTH  index of the current word.
- out_last  out  1  current beat is the final beat of this vector.
- busy  out  1  streaming is in progress.
- done  out  1  one-cycle pulse after the final beat has transferred.

## Operation
- States: IDLE and STREAM.
- IDLE, load=1:
  - Capture D into an internal snapshot register.
  - Set the index to the first word to emit.
  - Go to STREAM.
- IDLE, load=0: hold.
- STREAM:
  - out_valid=1. out_data and out_addr reflect the snapshot word at the current index.
  - A transfer happens when out_valid && out_ready.
  - On a transfer of a non-last beat, advance to the next emitted index.
  - On a transfer of the last beat, go to IDLE and register done=1 for one cycle.
- STREAM, load=1: ignored. The snapshot is not modified while busy.
- Changes on D after capture have no effect on the current stream.
- out_valid never depends combinationally on out_ready.
- While out_valid && !out_ready, out_data, out_addr and out_last hold stable.
- busy=1 exactly while in STREAM.
- Index arithmetic: unsigned. Indices never exceed NUM_WORDS-1, with no wrap within a stream.
- Index restart: the index restarts from the first emitted word on every accepted load.

## Timing
- All outputs are registered.
- Reset values: out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0, state=IDLE, snapshot=0.
- load sampled at edge T:
  - out_valid=1 and busy=1 from cycle T+1.
  - The first word is presented at T+1.
- With out_ready held high: one beat per cycle, so NUM_WORDS beats occupy cycles T+1 … T+NUM_WORDS.
- Last beat transfers at edge E:
  - At E+1: done=1, busy=0, out_valid=0, out_last=0.
  - A load sampled at E+1 is accepted, giving back-to-back vectors with a one-cycle gap.
- rst asserted mid-stream: all outputs go to their reset values immediately. No done pulse is produced. The partial stream is abandoned.

## Configuration
- RES_STREAM_SKIP_ZERO_EN undefined:
  - Every word is emitted, addresses 0 … NUM_WORDS-1 in order.
  - out_last is set with out_addr = NUM_WORDS-1.
- RES_STREAM_SKIP_ZERO_EN defined:
  - Only nonzero snapshot words are emitted, in ascending index order.
  - out_addr carries the true index.
  - out_last is set on the highest-indexed nonzero word.
  - All-zero snapshot: state stays IDLE, busy stays 0, no beats are emitted, and done=1 at T+1.
  - Throughput is unchanged: still one beat per cycle, with no bubbles between nonzero words.

## Structure
- Shared define header supplies `ROM_DATA_WIDTH, `REG_RES_SIZE and `REG_RES_ADDR_WIDTH. State encodings IDLE=1'b0 and STREAM=1'b1 are added there as `RES_STREAM_IDLE and `RES_STREAM_BUSY.
- Sub-module res_next_nz, used only under RES_STREAM_SKIP_ZERO_EN:
  - Combinational priority finder taking the NUM_WORDS nonzero mask and the current index.
  - Returns the next nonzero index above current, plus a none-left flag.
  - The same block also produces the first nonzero index and the all-zero flag.

## Test plan
- Basic stream: load D with words 0x0001…0x0008 and out_ready=1 → addresses 0…7 and data 1…8 on cycles T+1…T+8, out_last at addr 7, done at T+9.
- Back-pressure: same D, out_ready low for 3 cycles at addr 2 → data 0x0003 and addr 2 held stable for 3 cycles, no word dropped or duplicated, total 8 beats.
- Load while busy: pulse load with a different D at addr 4 → ignored; original words 5…8 finish, then a new load streams the new D.
- Reset mid-stream: rst at addr 3 → all outputs 0 asynchronously, no done pulse; a load after rst release streams from addr 0.
- Skip-zero (macro defined): D words {0,0x00A0,0,0,0x0BEE,0,0,0} → beats (addr 1, 0x00A0) then (addr 4, 0x0BEE) with out_last; done on the next cycle. All-zero D → no out_valid, done at T+1.
